// File: rtl/encoder_8to3_sync.sv
// encoder_8to3_sync: synchronised 8-to-3 priority encoder that emits
// one {code, any, multi} word per input change over valid/ready.
package encoder_8to3_sync_pkg;

  typedef struct packed {
    logic [2:0] code;
    logic       any;
    logic       multi;
  } enc_word_t;

endpackage

module encoder_8to3_sync
  import encoder_8to3_sync_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter bit PRIORITY_HIGH = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_lines,
  input  logic       out_ready,
  input  logic       ovr_clr,
  output logic       out_valid,
  output logic [2:0] out_code,
  output logic       out_any,
  output logic       out_multi,
  output logic       overrun
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_FULL  = 2'd1;
  localparam logic [1:0] S_PEND  = 2'd2;

  logic [7:0] sync_q [SYNC_STAGES];
  logic [7:0] s;

  enc_word_t  cur_w;
  enc_word_t  last_q;
  enc_word_t  out_q;
  enc_word_t  out_d;
  enc_word_t  pend_q;
  enc_word_t  pend_d;

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       evt;
  logic       ovr_q;
  logic       ovr_set;
  logic [3:0] cnt;
  logic [2:0] idx;

  assign s = sync_q[SYNC_STAGES-1];

  // Per-line flop chain taming the asynchronous switch inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= in_lines;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Priority encode plus any/multi flags; later loop hits win
  always_comb begin
    cur_w = '0;
    cnt   = '0;
    idx   = '0;
    for (int i = 0; i < 8; i++) begin
      idx = PRIORITY_HIGH ? 3'(i) : 3'(7 - i);
      if (s[idx]) begin
        cur_w.code = idx;
      end
      cnt = cnt + 4'(s[i]);
    end
    cur_w.any   = |s;
    cur_w.multi = cnt > 4'd1;
  end

  assign evt = cur_w != last_q;

  // Previous-cycle word, so only word changes raise an event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= '0;
    end else begin
      last_q <= cur_w;
    end
  end

  // Two-deep output/pending buffer control
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    pend_d  = pend_q;
    ovr_set = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (evt) begin
          out_d   = cur_w;
          state_d = S_FULL;
        end
      end
      S_FULL: begin
        unique case (1'b1)
          (out_ready && evt): begin
            out_d = cur_w;
          end
          (out_ready && !evt): begin
            state_d = S_EMPTY;
          end
          (!out_ready && evt): begin
            pend_d  = cur_w;
            state_d = S_PEND;
          end
          default: begin
          end
        endcase
      end
      S_PEND: begin
        unique case (1'b1)
          (out_ready && !evt): begin
            out_d   = pend_q;
            state_d = S_FULL;
          end
          (out_ready && evt): begin
            out_d  = pend_q;
            pend_d = cur_w;
          end
          (!out_ready && evt): begin
            pend_d  = cur_w;
            ovr_set = 1'b1;
          end
          default: begin
          end
        endcase
      end
      default: begin
        state_d = S_EMPTY;
      end
    endcase
  end

  // Buffer and state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      out_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      pend_q  <= pend_d;
    end
  end

  // Sticky overrun; a simultaneous set beats the clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_q <= 1'b0;
    end else if (ovr_set) begin
      ovr_q <= 1'b1;
    end else if (ovr_clr) begin
      ovr_q <= 1'b0;
    end
  end

  assign out_valid = state_q != S_EMPTY;
  assign out_code  = out_q.code;
  assign out_any   = out_q.any;
  assign out_multi = out_q.multi;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_encoder_8to3_sync.sv
// tb_encoder_8to3_sync: directed table, reset corner cases and random
// traffic against a queue-based reference for both priority modes.
module tb_encoder_8to3_sync;

  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_lines;
  logic       out_ready;
  logic       ovr_clr;

  logic       hi_valid, lo_valid;
  logic [2:0] hi_code, lo_code;
  logic       hi_any, lo_any;
  logic       hi_multi, lo_multi;
  logic       hi_ovr, lo_ovr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  encoder_8to3_sync #(.SYNC_STAGES(SS), .PRIORITY_HIGH(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_lines(in_lines),
    .out_ready(out_ready), .ovr_clr(ovr_clr),
    .out_valid(hi_valid), .out_code(hi_code), .out_any(hi_any),
    .out_multi(hi_multi), .overrun(hi_ovr)
  );

  encoder_8to3_sync #(.SYNC_STAGES(SS), .PRIORITY_HIGH(1'b0)) dut_lo (
    .clk(clk), .rst_n(rst_n), .in_lines(in_lines),
    .out_ready(out_ready), .ovr_clr(ovr_clr),
    .out_valid(lo_valid), .out_code(lo_code), .out_any(lo_any),
    .out_multi(lo_multi), .overrun(lo_ovr)
  );

  // Reference: delay line, word by arithmetic, up-to-two-entry queue
  logic [7:0] hist [SS];
  logic [4:0] last_w [2];
  logic [4:0] mq [2][2];
  int         mn [2];
  bit         m_ovr [2];

  function automatic logic [4:0] word_of(logic [7:0] v, bit hi);
    int x = int'(v);
    int c;
    if (x == 0) c = 0;
    else if (hi) c = $clog2(x + 1) - 1;
    else c = $clog2(x & -x);
    return {c[2:0], x != 0, $countones(v) > 1};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SS; i++) hist[i] = '0;
    for (int p = 0; p < 2; p++) begin
      last_w[p] = '0;
      mn[p] = 0;
      mq[p][0] = '0;
      mq[p][1] = '0;
      m_ovr[p] = 1'b0;
    end
  endtask

  task automatic model_edge();
    logic [4:0] w;
    bit ev, set;
    for (int p = 0; p < 2; p++) begin
      w = word_of(hist[SS-1], p == 0);
      ev = w != last_w[p];
      last_w[p] = w;
      set = 1'b0;
      if (mn[p] > 0 && out_ready) begin
        mq[p][0] = mq[p][1];
        mn[p]--;
      end
      if (ev) begin
        if (mn[p] < 2) begin
          mq[p][mn[p]] = w;
          mn[p]++;
        end else begin
          mq[p][1] = w;
          set = 1'b1;
        end
      end
      if (set) m_ovr[p] = 1'b1;
      else if (ovr_clr) m_ovr[p] = 1'b0;
    end
    for (int i = SS - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = in_lines;
  endtask

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  task automatic compare_model();
    logic [4:0] w;
    chk("hi_valid", 8'(hi_valid), 8'(mn[0] > 0));
    chk("lo_valid", 8'(lo_valid), 8'(mn[1] > 0));
    chk("hi_ovr", 8'(hi_ovr), 8'(m_ovr[0]));
    chk("lo_ovr", 8'(lo_ovr), 8'(m_ovr[1]));
    if (mn[0] > 0 && hi_valid) begin
      w = mq[0][0];
      chk("hi_word", 8'({hi_code, hi_any, hi_multi}), 8'(w));
    end
    if (mn[1] > 0 && lo_valid) begin
      w = mq[1][0];
      chk("lo_word", 8'({lo_code, lo_any, lo_multi}), 8'(w));
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    compare_model();
  endtask

  task automatic chk_all_zero(string nm);
    chk(nm, 8'({hi_valid, hi_code, hi_any, hi_multi, hi_ovr}), 8'h00);
    chk(nm, 8'({lo_valid, lo_code, lo_any, lo_multi, lo_ovr}), 8'h00);
  endtask

  typedef struct {
    logic [7:0] in;
    bit         rdy;
    bit         clr;
    bit         v;
    logic [2:0] code;
    bit         any;
    bit         multi;
    bit         ovr;
    logic [2:0] lcode;
  } vec_t;

  vec_t tbl [31];

  function automatic vec_t mk(logic [7:0] in, bit rdy, bit clr, bit v,
                              logic [2:0] code, bit any, bit multi,
                              bit ovr, logic [2:0] lcode);
    vec_t t;
    t.in = in; t.rdy = rdy; t.clr = clr; t.v = v;
    t.code = code; t.any = any; t.multi = multi;
    t.ovr = ovr; t.lcode = lcode;
    return t;
  endfunction

  initial begin
    int got;
    tbl[0]  = mk(8'h00, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(8'h00, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(8'h20, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(8'h20, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(8'h20, 1, 0, 1, 5, 1, 0, 0, 5);
    tbl[5]  = mk(8'h20, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(8'h00, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(8'h00, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[8]  = mk(8'h00, 1, 0, 1, 0, 0, 0, 0, 0);
    tbl[9]  = mk(8'h81, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[10] = mk(8'h81, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[11] = mk(8'h83, 1, 0, 1, 7, 1, 1, 0, 0);
    tbl[12] = mk(8'h83, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[13] = mk(8'h83, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[14] = mk(8'h83, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[15] = mk(8'h02, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[16] = mk(8'h04, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[17] = mk(8'h08, 0, 0, 1, 1, 1, 0, 0, 1);
    tbl[18] = mk(8'h08, 0, 0, 1, 1, 1, 0, 0, 1);
    tbl[19] = mk(8'h08, 0, 0, 1, 1, 1, 0, 1, 1);
    tbl[20] = mk(8'h08, 0, 0, 1, 1, 1, 0, 1, 1);
    tbl[21] = mk(8'h08, 1, 0, 1, 3, 1, 0, 1, 3);
    tbl[22] = mk(8'h08, 1, 0, 0, 0, 0, 0, 1, 0);
    tbl[23] = mk(8'h08, 1, 1, 0, 0, 0, 0, 0, 0);
    tbl[24] = mk(8'h08, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[25] = mk(8'h01, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[26] = mk(8'h02, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[27] = mk(8'h04, 0, 0, 1, 0, 1, 0, 0, 0);
    tbl[28] = mk(8'h08, 0, 0, 1, 0, 1, 0, 0, 0);
    tbl[29] = mk(8'h10, 0, 1, 1, 0, 1, 0, 1, 0);
    tbl[30] = mk(8'h10, 0, 0, 1, 0, 1, 0, 1, 0);

    rst_n = 1'b0;
    in_lines = 8'h00;
    out_ready = 1'b1;
    ovr_clr = 1'b0;
    model_reset();
    #1;
    chk_all_zero("reset_hold");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      step();
      chk_all_zero("idle_after_reset");
    end

    for (int i = 0; i < 31; i++) begin
      in_lines = tbl[i].in;
      out_ready = tbl[i].rdy;
      ovr_clr = tbl[i].clr;
      step();
      chk($sformatf("tbl%0d_valid", i), 8'(hi_valid), 8'(tbl[i].v));
      chk($sformatf("tbl%0d_ovr", i), 8'(hi_ovr), 8'(tbl[i].ovr));
      if (tbl[i].v) begin
        chk($sformatf("tbl%0d_code", i), 8'(hi_code), 8'(tbl[i].code));
        chk($sformatf("tbl%0d_any", i), 8'(hi_any), 8'(tbl[i].any));
        chk($sformatf("tbl%0d_multi", i), 8'(hi_multi), 8'(tbl[i].multi));
        chk($sformatf("tbl%0d_lo_code", i), 8'(lo_code), 8'(tbl[i].lcode));
      end
    end

    ovr_clr = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_all_zero("async_reset_mid_pend");
    in_lines = 8'h10;
    out_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    got = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (hi_valid) begin
        got++;
        chk("post_reset_code", 8'(hi_code), 8'd4);
      end
    end
    chk("post_reset_words", 8'(got), 8'd1);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 1) in_lines = 8'(1 << $urandom_range(0, 7));
        else in_lines = 8'($urandom);
      end
      if (i < 2000) out_ready = $urandom_range(0, 1) == 1;
      else out_ready = $urandom_range(0, 4) == 0;
      ovr_clr = $urandom_range(0, 11) == 0;
      if (i == 1500 || i == 3100) begin
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_all_zero("rand_async_reset");
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
